sram_req_arbiter: RTL and testbench
===================================

Name: sram_req_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (EX/MEM stage).
- Both sides use the req/addr_ok/data_ok split-transaction protocol. The block arbitrates address phases, locks a grant until it is accepted, and tracks outstanding transactions in an in-order ID FIFO so each data_ok/rdata returns to the requester that issued it.
- Sits between the pipeline stages and the SRAM/AXI bridge.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_OUTST, 2, maximum accepted-but-unanswered transactions (ID FIFO depth, >=1)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
inst_req  in  1  IF request valid
inst_wr  in  1  IF write (normally 0)
inst_size  in  2  access size (0=byte, 1=half, 2=word)
inst_addr  in  ADDR_W  IF address
inst_wstrb  in  4  IF byte strobes
inst_wdata  in  DATA_W  IF write data
inst_addr_ok  out  1  IF address phase accepted
inst_data_ok  out  1  IF response valid
inst_rdata  out  DATA_W  IF read data
data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata  in  (same widths)  data-side request
data_addr_ok, data_data_ok  out  1  data-side handshakes
data_rdata  out  DATA_W  data-side read data
mem_req  out  1  request to memory
mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata  out  (same widths)  muxed payload of granted source
mem_addr_ok  in  1  memory accepted address phase
mem_data_ok  in  1  memory response valid
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset: resetn low asynchronously clears the FIFO pointers and count and forces the grant state to IDLE. While resetn is low, mem_req and every *_addr_ok / *_data_ok output are 0. Reset mid-transaction discards all outstanding IDs; a late mem_data_ok after reset is ignored.
- Grant state machine, IDLE / HOLD_I / HOLD_D:
  - IDLE: fixed priority, data over inst. The selected source = data if data_req, else inst.
  - IDLE: if the selected source's req=1, FIFO not full and mem_addr_ok=0, go to HOLD_I or HOLD_D for that source.
  - HOLD_x: mux forced to source x regardless of the other requester.
  - HOLD_x: return to IDLE on a cycle where mem_req & mem_addr_ok, or if x_req drops (protocol violation; release, no push).
- mem_req = selected source's req & ~fifo_full.
- mem_* payload = selected source's payload. Payload is don't-care when mem_req=0.
- x_addr_ok = mem_addr_ok & mem_req & (selected source == x). This is combinational and zero-latency. The unselected source's addr_ok is always 0.
- ID FIFO (1-bit ID: 0=inst, 1=data):
  - Push: on mem_req & mem_addr_ok, push the selected source ID.
  - Pop: on mem_data_ok & ~empty, pop the head.
  - Push and pop in the same cycle: count unchanged, pointers both advance modulo MAX_OUTST.
  - Full: mem_req is held 0 even if a pop occurs that cycle. This is conservative and has no combinational path from data_ok to req.
- Responses:
  - inst_data_ok = mem_data_ok & ~empty & (head==0).
  - data_data_ok = mem_data_ok & ~empty & (head==1).
  - inst_rdata = data_rdata = mem_rdata (broadcast).
  - mem_data_ok while empty: ignored, no *_data_ok asserted.
- Same-cycle events: one acceptance and one response per cycle are fully independent. A response to inst may coincide with acceptance of a data request.
- Latency: zero added cycles on the address and response paths. All storage is state only (grant, FIFO).

Test Plan:
- Single fetch: inst_req=1, addr=0x1C000000, memory gives addr_ok same cycle and data_ok 1 cycle later with rdata=0x02800C0C -> mem_addr=0x1C000000; inst_addr_ok=1 at cycle 0; inst_data_ok=1, inst_rdata=0x02800C0C at cycle 1; data_data_ok=0.
- Priority: inst_req and data_req both 1 (data_addr=0x00001000), addr_ok=1 -> data accepted first, inst accepted next cycle; FIFO order data, inst; responses route data_data_ok then inst_data_ok.
- Grant lock: inst_req alone with mem_addr_ok=0 for 3 cycles, data_req rises in cycle 1 -> mem_addr stays at the inst address until addr_ok; data is granted only the cycle after inst is accepted.
- FIFO full with MAX_OUTST=2: two requests accepted with no data_ok -> third request sees mem_req=0 and no addr_ok until one data_ok pops; mem_data_ok with empty FIFO -> no *_data_ok.
- Reset mid-flight: 2 outstanding, pulse resetn low asynchronously (between edges) -> mem_req=0 immediately; after release the FIFO is empty and a stray mem_data_ok produces no output.
- Back-to-back stream: 8 alternating inst/data requests, random 0-3 cycle addr_ok and data_ok delays -> every response reaches its issuer in issue order, no drops or duplicates (scoreboard check).

Source files
------------

// File: rtl/sram_req_arbiter_if.sv
// One req/addr_ok/data_ok split-transaction SRAM port.
// The requester drives the master side and the responder drives the slave side.
interface sram_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        wstrb;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between the instruction and data requesters.
// An in-order ID FIFO routes each response back to the requester that issued it.
module sram_req_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic            clk,
  input  logic            resetn,
  sram_req_arbiter_if.slave  inst,
  sram_req_arbiter_if.slave  data,
  sram_req_arbiter_if.master mem
);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTST - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTST);

  typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

  state_t            state_reg, state_next;
  logic              id_mem [MAX_OUTST];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  logic              sel_data, sel_req, fifo_full, fifo_empty;
  logic              mem_req_int, push, pop, head_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A held grant pins the mux to its owner until the address phase is taken.
  always_comb begin
    sel_data = 1'b0;
    unique case (state_reg)
      HOLD_I:  sel_data = 1'b0;
      HOLD_D:  sel_data = 1'b1;
      default: sel_data = data.req;
    endcase
  end

  assign sel_req    = sel_data ? data.req : inst.req;
  assign fifo_full  = (count_reg == FULL_CNT);
  assign fifo_empty = (count_reg == '0);

  // Full blocks the request even when a pop lands this cycle: no data_ok -> req path.
  assign mem_req_int = resetn & sel_req & ~fifo_full;
  assign push        = mem_req_int & mem.addr_ok;
  assign pop         = resetn & mem.data_ok & ~fifo_empty;
  assign head_id     = id_mem[rd_ptr_reg];

  assign sel_addr  = sel_data ? data.addr  : inst.addr;
  assign sel_wdata = sel_data ? data.wdata : inst.wdata;

  assign mem.req   = mem_req_int;
  assign mem.wr    = sel_data ? data.wr    : inst.wr;
  assign mem.size  = sel_data ? data.size  : inst.size;
  assign mem.wstrb = sel_data ? data.wstrb : inst.wstrb;
  assign mem.addr  = sel_addr;
  assign mem.wdata = sel_wdata;

  assign inst.addr_ok = push & ~sel_data;
  assign data.addr_ok = push &  sel_data;
  assign inst.data_ok = pop  & ~head_id;
  assign data.data_ok = pop  &  head_id;
  assign inst.rdata   = mem.rdata;
  assign data.rdata   = mem.rdata;

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (sel_req && !fifo_full && !mem.addr_ok)
          state_next = sel_data ? HOLD_D : HOLD_I;
      end
      HOLD_I:  if (push || !inst.req) state_next = IDLE;
      HOLD_D:  if (push || !data.req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      unique case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ID storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr_reg] <= sel_data;
  end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter: vector table, directed corner cases,
// and a scoreboard that pairs every response with the request that produced it.
module tb_sram_req_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_OUTST = 2;
  localparam logic [31:0] IA  = 32'h1C00_0000;
  localparam logic [31:0] DA  = 32'h0000_1000;
  localparam logic [31:0] IWD = 32'h1111_1111;
  localparam logic [31:0] DWD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  sram_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) inst_if();
  sram_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) data_if();
  sram_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if();

  sram_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MAX_OUTST)) dut (
    .clk    (clk),
    .resetn (resetn),
    .inst   (inst_if),
    .data   (data_if),
    .mem    (mem_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        src;
    logic [31:0] rdata;
  } exp_t;

  // Field order: ireq dreq aok dok | ereq esrc eiaok edaok eidok eddok
  typedef struct packed {
    logic ireq, dreq, aok, dok;
    logic ereq, esrc, eiaok, edaok, eidok, eddok;
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] mem_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_resp = 0;
  vec_t        vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_5A5A;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = 2'd2;
    inst_if.wstrb = 4'hF; inst_if.wdata = IWD; inst_if.addr = IA;
    data_if.req = 1'b0; data_if.wr = 1'b1; data_if.size = 2'd1;
    data_if.wstrb = 4'h3; data_if.wdata = DWD; data_if.addr = DA;
    mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle_inputs();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic push_exp(input logic src, input logic [31:0] rd);
    exp_q.push_back(exp_t'{src: src, rdata: rd});
  endtask

  // Scoreboard: every response must match the oldest accepted request.
  always @(negedge clk) begin
    if (inst_if.data_ok || data_if.data_ok) begin
      if (inst_if.data_ok && data_if.data_ok) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_both_data_ok: got 2 responses required 1");
      end else if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_unexpected: got data_ok inst=%0b data=%0b required none",
                 inst_if.data_ok, data_if.data_ok);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_src", {63'd0, data_if.data_ok}, {63'd0, e.src});
        chk("sb_rdata", e.src ? data_if.rdata : inst_if.rdata, e.rdata);
        n_resp++;
      end
    end
  end

  initial begin
    int k, cyc, addr_dly, resp_dly, resp_base;
    logic [31:0] a0, a1, a2, cur_addr;

    vecs[0] = 10'b0000_000000;
    vecs[1] = 10'b1000_100000;
    vecs[2] = 10'b1010_101000;
    vecs[3] = 10'b0110_110100;
    vecs[4] = 10'b1110_110100;
    vecs[5] = 10'b1100_110000;
    vecs[6] = 10'b0001_000000;
    vecs[7] = 10'b0101_110000;
    vecs[8] = 10'b0010_000000;

    // Everything held low while resetn is low, even with all inputs active.
    idle_inputs();
    inst_if.req = 1'b1; data_if.req = 1'b1;
    mem_if.addr_ok = 1'b1; mem_if.data_ok = 1'b1;
    @(negedge clk);
    chk("rst_mem_req", mem_if.req, 0);
    chk("rst_inst_addr_ok", inst_if.addr_ok, 0);
    chk("rst_data_addr_ok", data_if.addr_ok, 0);
    chk("rst_inst_data_ok", inst_if.data_ok, 0);
    chk("rst_data_data_ok", data_if.data_ok, 0);

    // Single-cycle behaviour from an idle, empty arbiter.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      inst_if.req = vecs[v].ireq; data_if.req = vecs[v].dreq;
      mem_if.addr_ok = vecs[v].aok; mem_if.data_ok = vecs[v].dok;
      mem_if.rdata = 32'hCAFE_0000 + v;
      @(negedge clk);
      chk($sformatf("v%0d_mem_req", v), mem_if.req, vecs[v].ereq);
      chk($sformatf("v%0d_inst_addr_ok", v), inst_if.addr_ok, vecs[v].eiaok);
      chk($sformatf("v%0d_data_addr_ok", v), data_if.addr_ok, vecs[v].edaok);
      chk($sformatf("v%0d_inst_data_ok", v), inst_if.data_ok, vecs[v].eidok);
      chk($sformatf("v%0d_data_data_ok", v), data_if.data_ok, vecs[v].eddok);
      if (vecs[v].ereq) begin
        chk($sformatf("v%0d_mem_addr", v), mem_if.addr, vecs[v].esrc ? DA : IA);
        chk($sformatf("v%0d_mem_wr", v), mem_if.wr, vecs[v].esrc ? 1 : 0);
        chk($sformatf("v%0d_mem_size", v), mem_if.size, vecs[v].esrc ? 1 : 2);
        chk($sformatf("v%0d_mem_wstrb", v), mem_if.wstrb, vecs[v].esrc ? 4'h3 : 4'hF);
        chk($sformatf("v%0d_mem_wdata", v), mem_if.wdata, vecs[v].esrc ? DWD : IWD);
      end
    end

    // Single fetch with one-cycle response.
    do_reset();
    inst_if.req = 1'b1; inst_if.addr = 32'h1C00_0000; mem_if.addr_ok = 1'b1;
    @(negedge clk);
    chk("fetch_mem_addr", mem_if.addr, 32'h1C00_0000);
    chk("fetch_inst_addr_ok", inst_if.addr_ok, 1);
    push_exp(1'b0, 32'h0280_0C0C);
    step();
    inst_if.req = 1'b0; mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'h0280_0C0C;
    @(negedge clk);
    chk("fetch_inst_data_ok", inst_if.data_ok, 1);
    chk("fetch_inst_rdata", inst_if.rdata, 32'h0280_0C0C);
    chk("fetch_data_data_ok", data_if.data_ok, 0);
    step();
    idle_inputs();

    // Priority: data first, then inst; responses come back in that order.
    do_reset();
    inst_if.req = 1'b1; data_if.req = 1'b1; mem_if.addr_ok = 1'b1;
    @(negedge clk);
    chk("prio_data_addr_ok", data_if.addr_ok, 1);
    chk("prio_inst_addr_ok0", inst_if.addr_ok, 0);
    chk("prio_mem_addr_d", mem_if.addr, DA);
    push_exp(1'b1, 32'hAAAA_0001);
    step();
    data_if.req = 1'b0;
    @(negedge clk);
    chk("prio_inst_addr_ok1", inst_if.addr_ok, 1);
    chk("prio_mem_addr_i", mem_if.addr, IA);
    push_exp(1'b0, 32'hBBBB_0002);
    step();
    inst_if.req = 1'b0; mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'hAAAA_0001;
    @(negedge clk);
    chk("prio_resp1_data", data_if.data_ok, 1);
    step();
    mem_if.rdata = 32'hBBBB_0002;
    @(negedge clk);
    chk("prio_resp2_inst", inst_if.data_ok, 1);
    step();
    idle_inputs();

    // Grant lock: inst holds the port while addr_ok is withheld.
    do_reset();
    inst_if.req = 1'b1;
    @(negedge clk);
    chk("lock_c0_mem_addr", mem_if.addr, IA);
    step();
    data_if.req = 1'b1;
    @(negedge clk);
    chk("lock_c1_mem_addr", mem_if.addr, IA);
    step();
    @(negedge clk);
    chk("lock_c2_mem_addr", mem_if.addr, IA);
    step();
    mem_if.addr_ok = 1'b1;
    @(negedge clk);
    chk("lock_c3_inst_addr_ok", inst_if.addr_ok, 1);
    chk("lock_c3_data_addr_ok", data_if.addr_ok, 0);
    chk("lock_c3_mem_addr", mem_if.addr, IA);
    push_exp(1'b0, 32'h1111_AAAA);
    step();
    inst_if.req = 1'b0;
    @(negedge clk);
    chk("lock_c4_data_addr_ok", data_if.addr_ok, 1);
    chk("lock_c4_mem_addr", mem_if.addr, DA);
    push_exp(1'b1, 32'h2222_BBBB);
    step();
    data_if.req = 1'b0; mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'h1111_AAAA;
    @(negedge clk);
    chk("lock_resp1_inst", inst_if.data_ok, 1);
    step();
    mem_if.rdata = 32'h2222_BBBB;
    @(negedge clk);
    chk("lock_resp2_data", data_if.data_ok, 1);
    step();
    idle_inputs();

    // FIFO full: the third request waits until a response frees a slot.
    do_reset();
    a0 = 32'h1C00_0100; a1 = 32'h1C00_0104; a2 = 32'h1C00_0108;
    inst_if.req = 1'b1; inst_if.addr = a0; mem_if.addr_ok = 1'b1;
    @(negedge clk);
    chk("full_acc0", inst_if.addr_ok, 1);
    push_exp(1'b0, rd_of(a0));
    step();
    inst_if.addr = a1;
    @(negedge clk);
    chk("full_acc1", inst_if.addr_ok, 1);
    push_exp(1'b0, rd_of(a1));
    step();
    inst_if.addr = a2;
    @(negedge clk);
    chk("full_mem_req", mem_if.req, 0);
    chk("full_addr_ok", inst_if.addr_ok, 0);
    step();
    mem_if.data_ok = 1'b1; mem_if.rdata = rd_of(a0);
    @(negedge clk);
    chk("full_pop_mem_req", mem_if.req, 0);
    chk("full_pop_inst_data_ok", inst_if.data_ok, 1);
    step();
    mem_if.data_ok = 1'b0;
    @(negedge clk);
    chk("full_acc2_mem_req", mem_if.req, 1);
    chk("full_acc2", inst_if.addr_ok, 1);
    push_exp(1'b0, rd_of(a2));
    step();
    inst_if.req = 1'b0; mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b1; mem_if.rdata = rd_of(a1);
    @(negedge clk);
    chk("full_drain1", inst_if.data_ok, 1);
    step();
    mem_if.rdata = rd_of(a2);
    @(negedge clk);
    chk("full_drain2", inst_if.data_ok, 1);
    step();
    mem_if.rdata = 32'hFFFF_0000;
    @(negedge clk);
    chk("empty_inst_data_ok", inst_if.data_ok, 0);
    chk("empty_data_data_ok", data_if.data_ok, 0);
    step();
    idle_inputs();

    // Reset mid-flight with two outstanding IDs.
    do_reset();
    inst_if.req = 1'b1; data_if.req = 1'b1; mem_if.addr_ok = 1'b1;
    @(negedge clk);
    push_exp(1'b1, 32'h0);
    step();
    data_if.req = 1'b0;
    @(negedge clk);
    push_exp(1'b0, 32'h0);
    step();
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'h7777_7777;
    #1;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_mem_req", mem_if.req, 0);
    chk("midrst_inst_addr_ok", inst_if.addr_ok, 0);
    chk("midrst_inst_data_ok", inst_if.data_ok, 0);
    chk("midrst_data_data_ok", data_if.data_ok, 0);
    mem_if.addr_ok = 1'b0;
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("postrst_mem_req", mem_if.req, 1);
    chk("postrst_inst_data_ok", inst_if.data_ok, 0);
    chk("postrst_data_data_ok", data_if.data_ok, 0);
    step();
    inst_if.req = 1'b0;
    @(negedge clk);
    chk("postrst_stray_inst", inst_if.data_ok, 0);
    chk("postrst_stray_data", data_if.data_ok, 0);
    step();
    idle_inputs();

    // Alternating stream against a memory with random 0-3 cycle delays.
    do_reset();
    k = 0; cyc = 0; resp_base = n_resp;
    addr_dly = int'($urandom_range(0, 3));
    resp_dly = int'($urandom_range(0, 3));
    mem_q.delete();
    while ((k < 8 || mem_q.size() > 0) && cyc < 400) begin
      cur_addr = (k % 2 == 0) ? (32'h1C00_2000 + 32'(k * 4)) : (32'h0000_3000 + 32'(k * 4));
      inst_if.req  = (k < 8) && (k % 2 == 0);
      data_if.req  = (k < 8) && (k % 2 == 1);
      inst_if.addr = cur_addr;
      data_if.addr = cur_addr;
      mem_if.addr_ok = (addr_dly == 0);
      if (addr_dly > 0) addr_dly--;
      if (mem_q.size() > 0) begin
        mem_if.data_ok = (resp_dly == 0);
        mem_if.rdata   = mem_q[0];
        if (resp_dly > 0) resp_dly--;
      end else begin
        mem_if.data_ok = 1'b0;
      end
      @(negedge clk);
      if ((k % 2 == 0) ? inst_if.addr_ok : data_if.addr_ok) begin
        chk($sformatf("stream_k%0d_mem_addr", k), mem_if.addr, cur_addr);
        push_exp((k % 2) == 1, rd_of(cur_addr));
        k++;
      end
      if (mem_if.req && mem_if.addr_ok) begin
        mem_q.push_back(rd_of(mem_if.addr));
        addr_dly = int'($urandom_range(0, 3));
      end
      if (mem_if.data_ok && mem_q.size() > 0) begin
        void'(mem_q.pop_front());
        resp_dly = int'($urandom_range(0, 3));
      end
      step();
      cyc++;
    end
    idle_inputs();
    step();
    chk("stream_no_timeout", (cyc < 400) ? 1 : 0, 1);
    chk("stream_resp_count", n_resp - resp_base, 8);
    chk("stream_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
